card_shuffler: RTL and testbench

CARD_SHUFFLER -- requirements
Module: card_shuffler

---
 rtl/card_shuffler.sv | 192 +++++++++++++++++++
 tb/tb_card_shuffler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_shuffler.sv
// card_shuffler: deals CARDS/2 colour pairs into card memory in random order.
// A free-running LFSR drives a Fisher-Yates shuffle with rejection sampling,
// then the shuffled slots are written out to memory one address per cycle.
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   compute_colors_en level request, held high for the whole deal
//   compute_done      deal complete, held while compute_colors_en stays high
//   mem_we            card memory write strobe
//   mem_addr          card address 0..CARDS-1 (0 when mem_we is low)
//   mem_color         RGB444 card colour (0 when mem_we is low)
//   mem_state         card state, 2'b01 (covered) on writes, 0 otherwise
//   busy              high while initialising, shuffling or writing
module card_shuffler #(
   parameter int unsigned CARDS     = 12,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        compute_colors_en,
   output logic        compute_done,
   output logic        mem_we,
   output logic [3:0]  mem_addr,
   output logic [11:0] mem_color,
   output logic [1:0]  mem_state,
   output logic        busy
);

   localparam int unsigned AW = 4;
   localparam int unsigned CW = 12;
   localparam int unsigned PW = 3;
   localparam int unsigned LW = 16;
   localparam logic [AW-1:0] LAST = AW'(CARDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SHUFFLE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [LW-1:0]  lfsr_q, lfsr_d;
   logic [AW-1:0]  i_q, i_d;
   logic [AW-1:0]  wr_q, wr_d;
   logic [PW-1:0]  slot_q [CARDS];
   logic [PW-1:0]  slot_d [CARDS];
   logic [AW-1:0]  r;

   logic           done_d, we_d, busy_d;
   logic [AW-1:0]  addr_d;
   logic [CW-1:0]  color_d;
   logic [1:0]     mstate_d;

   logic           done_q, we_q, busy_q;
   logic [AW-1:0]  addr_q;
   logic [CW-1:0]  color_q;
   logic [1:0]     mstate_q;

   // Fixed six-colour palette
   function automatic logic [CW-1:0] palette(input logic [PW-1:0] idx);
      case (idx)
         3'd0:    palette = 12'hF00;
         3'd1:    palette = 12'h0F0;
         3'd2:    palette = 12'h00F;
         3'd3:    palette = 12'hFF0;
         3'd4:    palette = 12'hF0F;
         3'd5:    palette = 12'h0FF;
         default: palette = '0;
      endcase
   endfunction

   assign r = lfsr_q[AW-1:0];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; dropping the request aborts any active phase
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (compute_colors_en) state_d = S_INIT;
         end
         S_INIT: begin
            state_d = compute_colors_en ? S_SHUFFLE : S_IDLE;
         end
         S_SHUFFLE: begin
            if (!compute_colors_en) begin
               state_d = S_IDLE;
            end else if ((r <= i_q) && (i_q == AW'(1))) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!compute_colors_en) begin
               state_d = S_IDLE;
            end else if (wr_q == LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!compute_colors_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values; outputs follow the next state so
   // they line up with the cycle the FSM spends in that state
   always_comb begin
      lfsr_d = {lfsr_q[LW-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      i_d    = i_q;
      wr_d   = wr_q;
      slot_d = slot_q;

      case (state_q)
         S_INIT: begin
            if (compute_colors_en) begin
               for (int unsigned k = 0; k < CARDS; k++) slot_d[AW'(k)] = PW'(k >> 1);
               i_d = LAST;
            end
         end
         S_SHUFFLE: begin
            // Draws above i are rejected so every permutation stays equally likely
            if (compute_colors_en && (r <= i_q)) begin
               slot_d[i_q] = slot_q[r];
               slot_d[r]   = slot_q[i_q];
               if (i_q == AW'(1)) begin
                  wr_d = '0;
               end else begin
                  i_d = i_q - AW'(1);
               end
            end
         end
         S_WRITE: begin
            if (compute_colors_en && (wr_q != LAST)) wr_d = wr_q + AW'(1);
         end
         default: ;
      endcase

      done_d   = (state_d == S_DONE);
      busy_d   = (state_d == S_INIT) || (state_d == S_SHUFFLE) || (state_d == S_WRITE);
      we_d     = (state_d == S_WRITE);
      addr_d   = we_d ? wr_d : '0;
      color_d  = we_d ? palette(slot_d[wr_d]) : '0;
      mstate_d = we_d ? 2'b01 : 2'b00;
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q   <= LFSR_SEED;
         i_q      <= LAST;
         wr_q     <= '0;
         for (int unsigned k = 0; k < CARDS; k++) slot_q[AW'(k)] <= PW'(k >> 1);
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= '0;
         color_q  <= '0;
         mstate_q <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         i_q      <= i_d;
         wr_q     <= wr_d;
         slot_q   <= slot_d;
         done_q   <= done_d;
         we_q     <= we_d;
         busy_q   <= busy_d;
         addr_q   <= addr_d;
         color_q  <= color_d;
         mstate_q <= mstate_d;
      end
   end

   assign compute_done = done_q;
   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_color    = color_q;
   assign mem_state    = mstate_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_card_shuffler.sv
// Testbench for card_shuffler: reference LFSR/shuffle model feeding a
// write scoreboard, a table of deal scenarios, and hand-written reset,
// stall and abort sequences.
module tb_card_shuffler;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk, rst, en;
   logic        compute_done, mem_we, busy;
   logic [3:0]  mem_addr;
   logic [11:0] mem_color;
   logic [1:0]  mem_state;

   card_shuffler #(.CARDS(12), .LFSR_SEED(SEED)) dut (
      .clk               (clk),
      .rst               (rst),
      .compute_colors_en (en),
      .compute_done      (compute_done),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_color         (mem_color),
      .mem_state         (mem_state),
      .busy              (busy)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] lfsr_m;
   logic [15:0] exp_q [$];
   logic [15:0] exp_seq [12];
   logic [15:0] obs_seq [12];
   logic [15:0] seq_a_obs [12];
   logic [15:0] seq_a_exp [12];
   int          wr_seen;
   logic [11:0] pal [6] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF};

   typedef struct {
      bit do_rst;
      int idle;
      int drop_at;
      bit exp_done;
   } vec_t;

   vec_t vecs [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Reference LFSR, tracks the value visible during each cycle
   always @(posedge clk) begin
      if (rst) lfsr_m <= SEED;
      else     lfsr_m <= lfsr_step(lfsr_m);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one cycle and check the memory bus against the scoreboard
   task automatic tick();
      logic [15:0] e;
      @(negedge clk);
      if (mem_we) begin
         chk("write_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", int'(mem_addr), int'(e[15:12]));
            chk("wr_color", int'(mem_color), int'(e[11:0]));
            chk("wr_state", int'(mem_state), 1);
         end
         if (wr_seen < 12) obs_seq[wr_seen] = {mem_addr, mem_color};
         wr_seen++;
      end else begin
         chk("idle_bus_zero", int'({mem_addr, mem_color, mem_state}), 0);
      end
   endtask

   task automatic chk_reset_state(input string name);
      chk(name, int'({compute_done, busy, mem_we, mem_addr, mem_color, mem_state}), 0);
   endtask

   // Expected deal when the request is raised in a cycle whose LFSR value is l0
   task automatic model_deal(input logic [15:0] l0, output int rej);
      logic [2:0]  s [12];
      logic [2:0]  t;
      logic [15:0] l;
      logic [3:0]  rr;
      int          i;
      for (int k = 0; k < 12; k++) s[k] = 3'(k / 2);
      l   = lfsr_step(lfsr_step(l0));
      i   = 11;
      rej = 0;
      for (int n = 0; n < 5000; n++) begin
         rr = l[3:0];
         if (int'(rr) <= i) begin
            t        = s[i];
            s[i]     = s[rr];
            s[rr]    = t;
            if (i == 1) break;
            i--;
         end else begin
            rej++;
         end
         l = lfsr_step(l);
      end
      for (int k = 0; k < 12; k++) exp_seq[k] = {4'(k), pal[s[k]]};
   endtask

   task automatic run_deal(input int idle, input int drop_at, output bit done_seen, output int rej);
      int exp_lat;
      bit fin;
      int cnt [6];
      repeat (idle) tick();
      model_deal(lfsr_m, rej);
      exp_lat = 25 + rej;
      exp_q.delete();
      for (int k = 0; k < 12; k++) exp_q.push_back(exp_seq[k]);
      wr_seen   = 0;
      done_seen = 1'b0;
      fin       = 1'b0;
      en        = 1'b1;
      for (int lat = 1; lat <= 2000 && !fin; lat++) begin
         tick();
         if (compute_done) begin
            done_seen = 1'b1;
            fin       = 1'b1;
            chk("done_latency", lat, exp_lat);
            chk("writes_before_done", wr_seen, 12);
            chk("done_not_busy", int'(busy), 0);
         end else begin
            chk("busy_during_deal", int'(busy), 1);
            if (drop_at > 0 && wr_seen == drop_at) begin
               en = 1'b0;
               tick();
               chk("abort_we", int'(mem_we), 0);
               chk("abort_busy", int'(busy), 0);
               repeat (5) begin
                  tick();
                  chk("abort_no_done", int'(compute_done), 0);
               end
               chk("abort_writes_left", exp_q.size(), 12 - drop_at);
               fin = 1'b1;
            end
         end
      end
      chk("deal_finished", int'(fin), 1);
      if (done_seen) begin
         repeat (3) begin
            tick();
            chk("done_held", int'(compute_done), 1);
         end
         en = 1'b0;
         tick();
         chk("done_cleared", int'(compute_done), 0);
         chk("idle_busy", int'(busy), 0);
         for (int c = 0; c < 6; c++) cnt[c] = 0;
         for (int k = 0; k < 12; k++)
            for (int c = 0; c < 6; c++)
               if (obs_seq[k][11:0] == pal[c]) cnt[c]++;
         for (int c = 0; c < 6; c++) chk("pair_count", cnt[c], 2);
      end
      en = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      bit  done;
      int  rej;
      int  found;
      int  same;
      bit  diff_obs, diff_exp;
      logic [15:0] l, a, b, c;

      vecs[0] = '{1'b1, 0, 0, 1'b1};   // request held from reset release
      vecs[1] = '{1'b1, 0, 0, 1'b1};   // identical timing, identical deal
      vecs[2] = '{1'b1, 7, 0, 1'b1};   // later start after reset
      vecs[3] = '{1'b0, 3, 5, 1'b0};   // abort on the 5th write
      vecs[4] = '{1'b0, 0, 0, 1'b1};   // re-raise after abort
      vecs[5] = '{1'b0, 25, 0, 1'b1};  // long idle gap

      rst     = 1'b1;
      en      = 1'b0;
      wr_seen = 0;
      tick();
      tick();
      rst = 1'b0;
      chk_reset_state("reset_state");
      repeat (10) begin
         tick();
         chk("idle_done", int'(compute_done), 0);
         chk("idle_busy_after_reset", int'(busy), 0);
         chk("idle_we", int'(mem_we), 0);
      end

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].do_rst) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_reset_state("vec_reset_state");
         end
         run_deal(vecs[v].idle, vecs[v].drop_at, done, rej);
         chk("vec_done_flag", int'(done), int'(vecs[v].exp_done));
         if (v == 0) begin
            seq_a_obs = obs_seq;
            seq_a_exp = exp_seq;
         end else if (v == 1) begin
            same = 0;
            for (int k = 0; k < 12; k++) if (obs_seq[k] == seq_a_obs[k]) same++;
            chk("repeat_identical", same, 12);
         end else if (v == 2) begin
            diff_obs = 1'b0;
            diff_exp = 1'b0;
            for (int k = 0; k < 12; k++) begin
               if (obs_seq[k] != seq_a_obs[k]) diff_obs = 1'b1;
               if (exp_seq[k] != seq_a_exp[k]) diff_exp = 1'b1;
            end
            if (diff_exp) chk("offset_changes_deal", int'(diff_obs), 1);
         end
      end

      // Find a start offset whose first three draws at i=11 are all rejected
      found = -1;
      l     = lfsr_m;
      for (int d = 0; d < 4000 && found < 0; d++) begin
         a = lfsr_step(lfsr_step(l));
         b = lfsr_step(a);
         c = lfsr_step(b);
         if (a[3:0] > 4'd11 && b[3:0] > 4'd11 && c[3:0] > 4'd11) found = d;
         l = lfsr_step(l);
      end
      chk("stall_offset_found", int'(found >= 0), 1);
      if (found >= 0) begin
         run_deal(found, 0, done, rej);
         chk("stall_deal_done", int'(done), 1);
         chk("stall_rejects_min3", int'(rej >= 3), 1);
      end

      // Reset in the middle of the shuffle with the request still high
      en = 1'b1;
      repeat (5) tick();
      chk("mid_shuffle_busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      chk_reset_state("mid_shuffle_reset_state");
      rst = 1'b0;
      en  = 1'b0;
      tick();
      chk_reset_state("post_reset_idle");
      run_deal(2, 0, done, rej);
      chk("post_reset_deal_done", int'(done), 1);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
